imuldiv_div_arbiter: RTL

Round-robin arbiter that shares one iterative divide unit between two independent requesters (e.g. two issue ports). It accepts one val/rdy request at a time, forwards it on the divider's `divreq_*` interface, captures the `divresp_*` result and returns it to the owning requester. At most one operation is outstanding at any time.

---
 rtl/imuldiv_div_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/imuldiv_div_arbiter.sv
// Round-robin arbiter sharing one iterative divider between two requesters.
// Optional IMULDIV_DIV_ARB_DBZ_FAST_EN answers divide-by-zero locally without the divider.
module imuldiv_div_arbiter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_val,
    output logic              req0_rdy,
    input  logic              req0_msg_fn,
    input  logic [XLEN-1:0]   req0_msg_a,
    input  logic [XLEN-1:0]   req0_msg_b,
    input  logic              req1_val,
    output logic              req1_rdy,
    input  logic              req1_msg_fn,
    input  logic [XLEN-1:0]   req1_msg_a,
    input  logic [XLEN-1:0]   req1_msg_b,
    output logic              resp0_val,
    input  logic              resp0_rdy,
    output logic [2*XLEN-1:0] resp0_msg_result,
    output logic              resp1_val,
    input  logic              resp1_rdy,
    output logic [2*XLEN-1:0] resp1_msg_result,
    output logic              divreq_val,
    input  logic              divreq_rdy,
    output logic              divreq_msg_fn,
    output logic [XLEN-1:0]   divreq_msg_a,
    output logic [XLEN-1:0]   divreq_msg_b,
    input  logic              divresp_val,
    output logic              divresp_rdy,
    input  logic [2*XLEN-1:0] divresp_msg_result,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              prio_r;
    logic              prio_next_s;
    logic              owner_r;
    logic              owner_next_s;
    logic              grant_next_s;
    logic              fn_r;
    logic [XLEN-1:0]   a_r;
    logic [XLEN-1:0]   b_r;
    logic [2*XLEN-1:0] result_r;
    logic              fire0_s;
    logic              fire1_s;
    logic              fire_s;
    logic              sel_fn_s;
    logic [XLEN-1:0]   sel_a_s;
    logic [XLEN-1:0]   sel_b_s;
    logic              dbz_s;
    logic              resp_rdy_s;

    // rdy outputs are registers, so a fire only depends on the val seen at the edge
    assign fire0_s  = req0_rdy & req0_val;
    assign fire1_s  = req1_rdy & req1_val;
    assign fire_s   = fire0_s | fire1_s;
    assign sel_fn_s = fire1_s ? req1_msg_fn : req0_msg_fn;
    assign sel_a_s  = fire1_s ? req1_msg_a  : req0_msg_a;
    assign sel_b_s  = fire1_s ? req1_msg_b  : req0_msg_b;
    assign resp_rdy_s = owner_r ? resp1_rdy : resp0_rdy;

`ifdef IMULDIV_DIV_ARB_DBZ_FAST_EN
    assign dbz_s = fire_s && (sel_b_s == {XLEN{1'b0}});
`else
    assign dbz_s = 1'b0;
`endif

    assign divreq_msg_fn    = fn_r;
    assign divreq_msg_a     = a_r;
    assign divreq_msg_b     = b_r;
    assign resp0_msg_result = result_r;
    assign resp1_msg_result = result_r;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, priority and owner decode
    always_comb begin
        state_next_s = state_r;
        prio_next_s  = prio_r;
        owner_next_s = owner_r;
        case (state_r)
            IDLE: begin
                if (fire_s) begin
                    state_next_s = dbz_s ? RESP : ISSUE;
                    owner_next_s = fire1_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (divreq_rdy) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            WAIT: begin
                if (divresp_val) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                if (resp_rdy_s) begin
                    state_next_s = IDLE;
                    prio_next_s  = ~owner_r;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Grant for the next IDLE cycle, using the priority that will be in force then
    always_comb begin
        grant_next_s = prio_next_s;
        if (req0_val && !req1_val) begin
            grant_next_s = 1'b0;
        end else if (req1_val && !req0_val) begin
            grant_next_s = 1'b1;
        end else begin
            grant_next_s = prio_next_s;
        end
    end

    // Moore outputs registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req0_rdy    <= 1'b0;
            req1_rdy    <= 1'b0;
            divreq_val  <= 1'b0;
            divresp_rdy <= 1'b0;
            resp0_val   <= 1'b0;
            resp1_val   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            req0_rdy    <= (state_next_s == IDLE) && !grant_next_s;
            req1_rdy    <= (state_next_s == IDLE) && grant_next_s;
            divreq_val  <= (state_next_s == ISSUE);
            divresp_rdy <= (state_next_s == WAIT);
            resp0_val   <= (state_next_s == RESP) && !owner_next_s;
            resp1_val   <= (state_next_s == RESP) && owner_next_s;
            busy        <= (state_next_s != IDLE);
        end
    end

    // Latched request, owner, priority and result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_r   <= 1'b0;
            owner_r  <= 1'b0;
            fn_r     <= 1'b0;
            a_r      <= {XLEN{1'b0}};
            b_r      <= {XLEN{1'b0}};
            result_r <= {(2*XLEN){1'b0}};
        end else begin
            prio_r  <= prio_next_s;
            owner_r <= owner_next_s;
            if (fire_s) begin
                fn_r <= sel_fn_s;
                a_r  <= sel_a_s;
                b_r  <= sel_b_s;
            end
            if (dbz_s) begin
                result_r <= {sel_a_s, {XLEN{1'b1}}};
            end else if ((state_r == WAIT) && divresp_val) begin
                result_r <= divresp_msg_result;
            end
        end
    end

endmodule
